// File: rtl/counter_monitor_if.sv
// Pin bundle of the monitored loadable up/down counter.
interface counter_monitor_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             load;
  logic             up_down;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] count;

  // Side that drives the counter pins (the counter itself, or a bench).
  modport master (
    output load,
    output up_down,
    output din,
    output count
  );

  // Passive observer side.
  modport slave (
    input load,
    input up_down,
    input din,
    input count
  );

endinterface : counter_monitor_if

// File: rtl/counter_monitor.sv
// Passive checker for the loadable up/down counter: predicts the next count,
// flags mismatches, records the first one and counts errors and wraps.
module counter_monitor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mon_en,
  input  logic                clr,
  counter_monitor_if.slave    mon,
  output logic                synced,
  output logic                err_pulse,
  output logic                err_sticky,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [WIDTH-1:0]    first_exp,
  output logic [WIDTH-1:0]    first_act,
  output logic [ERR_W-1:0]    wrap_up_cnt,
  output logic [ERR_W-1:0]    wrap_dn_cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ERR_W-1:0] SAT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_pred_en;
  logic             w_check;
  logic             w_mismatch;
  logic             w_wrap_up;
  logic             w_wrap_dn;
  logic [WIDTH-1:0] w_next_val;

  logic [WIDTH-1:0] r_pred;
  logic             r_prev_load;
  logic             r_prev_dn;
  logic             r_synced;
  logic             r_err_pulse;
  logic             r_err_sticky;
  logic [ERR_W-1:0] r_err_cnt;
  logic [WIDTH-1:0] r_first_exp;
  logic [WIDTH-1:0] r_first_act;
  logic [ERR_W-1:0] r_wrap_up_cnt;
  logic [ERR_W-1:0] r_wrap_dn_cnt;

  // Next counter value from the observed count; load beats direction.
  always_comb begin
    w_next_val = '0;
    if (mon.load) begin
      w_next_val = mon.din;
    end else if (mon.up_down) begin
      w_next_val = mon.count - WIDTH'(1);
    end else begin
      w_next_val = mon.count + WIDTH'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus prediction/compare enables.
  always_comb begin
    w_state_nxt = r_state;
    w_pred_en   = 1'b0;
    w_check     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mon_en) w_state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        if (!mon_en) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_pred_en   = 1'b1;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!mon_en) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_pred_en = 1'b1;
          w_check   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Compare and wrap detection; a wrap is only credited on a correct count
  // that followed a non-load step in the matching direction.
  always_comb begin
    w_mismatch = w_check && (mon.count != r_pred);
    w_wrap_up  = w_check && !w_mismatch && !r_prev_load && !r_prev_dn &&
                 (r_pred == '0);
    w_wrap_dn  = w_check && !w_mismatch && !r_prev_load && r_prev_dn &&
                 (r_pred == CNT_MAX);
  end

  // Prediction, error capture and saturating statistics; clr beats a mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred        <= '0;
      r_prev_load   <= 1'b0;
      r_prev_dn     <= 1'b0;
      r_synced      <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_err_cnt     <= '0;
      r_first_exp   <= '0;
      r_first_act   <= '0;
      r_wrap_up_cnt <= '0;
      r_wrap_dn_cnt <= '0;
    end else begin
      r_synced <= (w_state_nxt == ST_CHECK);
      if (w_pred_en) begin
        r_pred      <= w_next_val;
        r_prev_load <= mon.load;
        r_prev_dn   <= mon.up_down;
      end
      if (clr) begin
        r_err_pulse   <= 1'b0;
        r_err_sticky  <= 1'b0;
        r_err_cnt     <= '0;
        r_first_exp   <= '0;
        r_first_act   <= '0;
        r_wrap_up_cnt <= '0;
        r_wrap_dn_cnt <= '0;
      end else begin
        r_err_pulse <= w_mismatch;
        if (w_mismatch) begin
          if (r_err_cnt != SAT_MAX) r_err_cnt <= r_err_cnt + ERR_W'(1);
          if (!r_err_sticky) begin
            r_err_sticky <= 1'b1;
            r_first_exp  <= r_pred;
            r_first_act  <= mon.count;
          end
        end
        if (w_wrap_up && (r_wrap_up_cnt != SAT_MAX)) begin
          r_wrap_up_cnt <= r_wrap_up_cnt + ERR_W'(1);
        end
        if (w_wrap_dn && (r_wrap_dn_cnt != SAT_MAX)) begin
          r_wrap_dn_cnt <= r_wrap_dn_cnt + ERR_W'(1);
        end
      end
    end
  end

  assign synced      = r_synced;
  assign err_pulse   = r_err_pulse;
  assign err_sticky  = r_err_sticky;
  assign err_cnt     = r_err_cnt;
  assign first_exp   = r_first_exp;
  assign first_act   = r_first_act;
  assign wrap_up_cnt = r_wrap_up_cnt;
  assign wrap_dn_cnt = r_wrap_dn_cnt;

endmodule : counter_monitor

// File: tb/tb_counter_monitor.sv
// Directed self-checking bench for counter_monitor.
module tb_counter_monitor;

  logic       clk;
  logic       rst_n;
  logic       mon_en;
  logic       clr;
  logic       synced;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic [3:0] first_exp;
  logic [3:0] first_act;
  logic [7:0] wrap_up_cnt;
  logic [7:0] wrap_dn_cnt;

  int n_tests;
  int n_fail;

  counter_monitor_if #(.WIDTH(4)) u_if ();

  counter_monitor #(.WIDTH(4), .ERR_W(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mon_en      (mon_en),
    .clr         (clr),
    .mon         (u_if),
    .synced      (synced),
    .err_pulse   (err_pulse),
    .err_sticky  (err_sticky),
    .err_cnt     (err_cnt),
    .first_exp   (first_exp),
    .first_act   (first_act),
    .wrap_up_cnt (wrap_up_cnt),
    .wrap_dn_cnt (wrap_dn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of counter pins, let one edge pass, settle 1ns after it.
  task automatic cyc(input logic ld, input logic dn, input logic [3:0] d,
                     input logic [3:0] c);
    u_if.load    = ld;
    u_if.up_down = dn;
    u_if.din     = d;
    u_if.count   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mon_en = 1'b0; clr = 1'b0;
    u_if.load = 1'b0; u_if.up_down = 1'b0; u_if.din = 4'd0; u_if.count = 4'd0;
    #2;
    n_tests++; if ({synced, err_pulse, err_sticky, err_cnt, first_exp, first_act, wrap_up_cnt, wrap_dn_cnt} !== 35'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {synced, err_pulse, err_sticky, err_cnt, first_exp, first_act, wrap_up_cnt, wrap_dn_cnt}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    mon_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      cyc(1'b0, 1'b0, 4'd0, 4'(i % 16));
      if (i == 0) begin
        n_tests++; if (synced !== 1'b0) begin n_fail++; $display("FAIL free_run_synced_edge1: got %0d want 0", synced); end
      end
      if (i == 1) begin
        n_tests++; if (synced !== 1'b1) begin n_fail++; $display("FAIL free_run_synced_edge2: got %0d want 1", synced); end
      end
    end
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL free_run_err_cnt: got %0d want 0", err_cnt); end
    n_tests++; if (wrap_up_cnt !== 8'd1) begin n_fail++; $display("FAIL free_run_wrap_up: got %0d want 1", wrap_up_cnt); end
    n_tests++; if (wrap_dn_cnt !== 8'd0) begin n_fail++; $display("FAIL free_run_wrap_dn: got %0d want 0", wrap_dn_cnt); end
  endtask

  task automatic test_load_down();
    cyc(1'b1, 1'b1, 4'd9, 4'd2);
    cyc(1'b0, 1'b1, 4'd0, 4'd9);
    n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL load_priority_pulse: got %0d want 0", err_pulse); end
    cyc(1'b0, 1'b1, 4'd0, 4'd8);
    cyc(1'b0, 1'b1, 4'd0, 4'd7);
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL load_down_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_wrap_down();
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 4'd0, 4'(6 - i));
    n_tests++; if (wrap_dn_cnt !== 8'd1) begin n_fail++; $display("FAIL wrap_dn_count: got %0d want 1", wrap_dn_cnt); end
    n_tests++; if (wrap_up_cnt !== 8'd1) begin n_fail++; $display("FAIL wrap_dn_no_up: got %0d want 1", wrap_up_cnt); end
    cyc(1'b1, 1'b1, 4'd0, 4'd13);
    cyc(1'b1, 1'b1, 4'd15, 4'd0);
    cyc(1'b0, 1'b1, 4'd0, 4'd15);
    n_tests++; if (wrap_dn_cnt !== 8'd1) begin n_fail++; $display("FAIL load_no_wrap: got %0d want 1", wrap_dn_cnt); end
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_mismatch();
    cyc(1'b1, 1'b0, 4'd2, 4'd14);
    cyc(1'b0, 1'b0, 4'd0, 4'd2);
    cyc(1'b0, 1'b0, 4'd0, 4'd5);
    n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL mismatch_pulse: got %0d want 1", err_pulse); end
    n_tests++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL mismatch_err_cnt: got %0d want 1", err_cnt); end
    n_tests++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL mismatch_sticky: got %0d want 1", err_sticky); end
    n_tests++; if (first_exp !== 4'd3) begin n_fail++; $display("FAIL mismatch_first_exp: got %0d want 3", first_exp); end
    n_tests++; if (first_act !== 4'd5) begin n_fail++; $display("FAIL mismatch_first_act: got %0d want 5", first_act); end
    cyc(1'b0, 1'b0, 4'd0, 4'd6);
    n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL mismatch_pulse_drop: got %0d want 0", err_pulse); end
    n_tests++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL mismatch_resync_cnt: got %0d want 1", err_cnt); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 1'b0, 4'd0, 4'd0);
      if (i == 99) begin
        n_tests++; if (err_cnt !== 8'd101) begin n_fail++; $display("FAIL sat_midway_cnt: got %0d want 101", err_cnt); end
      end
    end
    n_tests++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_err_cnt: got %0d want 255", err_cnt); end
    n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_pulse: got %0d want 1", err_pulse); end
    n_tests++; if ({first_exp, first_act} !== {4'd3, 4'd5}) begin n_fail++; $display("FAIL sat_first_hold: got %0d/%0d want 3/5", first_exp, first_act); end
  endtask

  task automatic test_clr_same_edge();
    clr = 1'b1;
    cyc(1'b0, 1'b0, 4'd0, 4'd0);
    clr = 1'b0;
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_err_cnt: got %0d want 0", err_cnt); end
    n_tests++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_sticky: got %0d want 0", err_sticky); end
    n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL clr_pulse: got %0d want 0", err_pulse); end
    n_tests++; if ({first_exp, first_act, wrap_up_cnt, wrap_dn_cnt} !== 24'd0) begin n_fail++; $display("FAIL clr_capture_wraps: got %h want 0", {first_exp, first_act, wrap_up_cnt, wrap_dn_cnt}); end
    n_tests++; if (synced !== 1'b1) begin n_fail++; $display("FAIL clr_keeps_state: got %0d want 1", synced); end
    cyc(1'b0, 1'b0, 4'd0, 4'd1);
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_pred_kept: got %0d want 0", err_cnt); end
  endtask

  task automatic test_counter_reset();
    cyc(1'b0, 1'b0, 4'd0, 4'd0);
    n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL cnt_rst_pulse: got %0d want 1", err_pulse); end
    n_tests++; if ({first_exp, first_act} !== {4'd2, 4'd0}) begin n_fail++; $display("FAIL cnt_rst_capture: got %0d/%0d want 2/0", first_exp, first_act); end
    cyc(1'b0, 1'b0, 4'd0, 4'd1);
    n_tests++; if ({err_pulse, err_cnt} !== {1'b0, 8'd1}) begin n_fail++; $display("FAIL cnt_rst_resume: got pulse %0d cnt %0d want 0/1", err_pulse, err_cnt); end
  endtask

  task automatic test_mon_en_off();
    mon_en = 1'b0;
    cyc(1'b0, 1'b0, 4'd0, 4'd9);
    n_tests++; if (synced !== 1'b0) begin n_fail++; $display("FAIL en_off_synced: got %0d want 0", synced); end
    n_tests++; if ({err_pulse, err_cnt, err_sticky} !== {1'b0, 8'd1, 1'b1}) begin n_fail++; $display("FAIL en_off_hold: got pulse %0d cnt %0d sticky %0d want 0/1/1", err_pulse, err_cnt, err_sticky); end
    mon_en = 1'b1;
    cyc(1'b0, 1'b0, 4'd0, 4'd3);
    n_tests++; if (synced !== 1'b0) begin n_fail++; $display("FAIL reenable_sync_wait: got %0d want 0", synced); end
    cyc(1'b0, 1'b0, 4'd0, 4'd4);
    cyc(1'b0, 1'b0, 4'd0, 4'd5);
    n_tests++; if ({synced, err_pulse, err_cnt} !== {1'b1, 1'b0, 8'd1}) begin n_fail++; $display("FAIL reenable_track: got synced %0d pulse %0d cnt %0d want 1/0/1", synced, err_pulse, err_cnt); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if ({synced, err_pulse, err_sticky, err_cnt, first_exp, first_act, wrap_up_cnt, wrap_dn_cnt} !== 35'd0) begin n_fail++; $display("FAIL async_reset_outputs: got %h want 0", {synced, err_pulse, err_sticky, err_cnt, first_exp, first_act, wrap_up_cnt, wrap_dn_cnt}); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 4'd0, 4'd7);
    n_tests++; if (synced !== 1'b0) begin n_fail++; $display("FAIL async_reset_resync: got %0d want 0", synced); end
    cyc(1'b0, 1'b0, 4'd0, 4'd8);
    cyc(1'b0, 1'b0, 4'd0, 4'd9);
    n_tests++; if ({synced, err_cnt} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL async_reset_track: got synced %0d cnt %0d want 1/0", synced, err_cnt); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_free_run();
    test_load_down();
    test_wrap_down();
    test_mismatch();
    test_saturate();
    test_clr_same_edge();
    test_counter_reset();
    test_mon_en_off();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_counter_monitor

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
- Passive checker that sits on the pin interface of the team's loadable 4-bit up/down counter: clk, rst_n, load, up_down, din, count.
- It observes the same inputs the counter sees and predicts the next count every cycle.
- It compares the prediction against the observed count and reports mismatches, error statistics and wrap events.
- Used in the bench and as optional in-silicon self-check; it never drives the counter.

Parameters:
- WIDTH, 4, width of din/count/expected values.
- ERR_W, 8, width of saturating error and wrap counters.

Ports:
- clk  in  1  clock, same domain as monitored counter.
- rst_n  in  1  asynchronous, active-low reset.
- mon_en  in  1  monitor enable; 0 = idle, no checking.
- clr  in  1  synchronous clear of counters and sticky capture.
- load  in  1  observed counter load strobe.
- up_down  in  1  observed direction; 0 = up, 1 = down.
- din  in  WIDTH  observed load value.
- count  in  WIDTH  observed counter output.
- synced  out  1  prediction valid, compares active.
- err_pulse  out  1  one-cycle mismatch flag.
- err_sticky  out  1  set on first mismatch, held until clr.
- err_cnt  out  ERR_W  saturating mismatch count.
- first_exp  out  WIDTH  expected value at first mismatch.
- first_act  out  WIDTH  observed value at first mismatch.
- wrap_up_cnt  out  ERR_W  saturating count of observed up wraps (max -> 0).
- wrap_dn_cnt  out  ERR_W  saturating count of observed down wraps (0 -> max).

Behaviour:
- Reset (rst_n low, async): state IDLE; pred = 0; all outputs 0.
- Notation: at posedge k, sample count_k, load_k, up_down_k, din_k.
- Next-value function f:
  - load = 1 -> din.
  - up_down = 0 -> count + 1, modulo 2^WIDTH (max wraps to 0).
  - up_down = 1 -> count - 1, modulo 2^WIDTH (0 wraps to max).
  - load has priority over direction.
- FSM:
  - IDLE: synced = 0, no compares. mon_en = 1 at edge k -> SYNC.
  - SYNC: at edge k, pred <= f(count_k, inputs_k). Next state CHECK; synced = 1 from the cycle after this edge.
  - CHECK: at each edge k:
    - mismatch = (count_k != pred); err_pulse <= mismatch.
    - pred <= f(count_k, inputs_k). Prediction always uses the observed count, so one fault gives exactly one error.
  - mon_en = 0 in SYNC or CHECK -> IDLE at that edge; err_pulse <= 0; statistics hold.
- Latency: err_pulse is high in the cycle after the edge that sampled the bad count.
- Error capture: on a mismatch with err_sticky = 0, first_exp <= pred, first_act <= count_k, err_sticky <= 1. Later mismatches do not update the captured values.
- err_cnt increments per mismatch and saturates at 2^ERR_W - 1.
- Wraps (CHECK only, load_{k-1} = 0 and no mismatch):
  - pred = 0 with previous direction up -> wrap_up_cnt++.
  - pred = max with previous direction down -> wrap_dn_cnt++.
  - Both counters saturate.
- clr at edge k:
  - Zeroes err_cnt, wrap counters, err_sticky, first_exp, first_act.
  - Also zeroes err_pulse for that edge.
  - FSM state and pred are unaffected.
  - A mismatch on the same edge is discarded; clr wins.
- Reset mid-operation: immediate return to IDLE with all outputs 0; resync required.
- Counter reset while the monitor runs: the counter's count = 0 not predicted by the monitor is flagged once, then tracking resumes.

Test Plan:
- Reset, mon_en = 1, up_down = 0, count free-runs 0..15..0 -> synced = 1 after 2 edges; err_cnt = 0; wrap_up_cnt = 1 after the 15 -> 0 transition.
- load = 1, din = 9 for one cycle, then up_down = 1 -> count sequence 9, 8, 7, no error; load wins when up_down is toggled on the same edge.
- Down through 0 (count 1, 0, 15) -> wrap_dn_cnt = 1; load of 0 followed by 15 with load still 1 does not count as a wrap.
- Force count = 5 where 3 is expected -> err_pulse high exactly one cycle; err_cnt = 1; first_exp = 3, first_act = 5; no error on the next cycle if the counter continues 6.
- Inject 300 mismatches -> err_cnt saturates at 255; first_exp/first_act still hold the first error.
- clr on the same edge as a mismatch -> err_cnt = 0, err_sticky = 0, err_pulse = 0; mon_en = 0 -> synced = 0 next cycle; async rst_n mid-count -> all outputs 0 immediately.
